cordic_engine: RTL and testbench

Parametrised iterative CORDIC engine; successor to the fixed rotation-only sine/cosine core. Adds rotation and vectoring modes, full-circle quadrant pre-rotation, optional internal gain compensation, ready/valid handshakes on both sides with output backpressure, and a range-error flag. Sits between the angle/vector producer and downstream DSP consumers. Processes one operation at a time.

---
 rtl/cordic_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_cordic_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_engine
// Purpose  : Iterative CORDIC engine, one operation in flight at a time.
//            Rotation mode (mode=0) rotates (x_in,y_in) by angle z_in.
//            Vectoring mode (mode=1) returns magnitude and atan2(y_in,x_in).
//            Full-circle coverage through quadrant pre-rotation on load;
//            optional gain compensation by K on the final result.
// Ports    : clk, arst            - clock, asynchronous active-high reset
//            mode, in_valid/ready - operand handshake, x_in/y_in/z_in operands
//            out_valid/ready      - result handshake, x_out/y_out/z_out results
//            range_err            - rotation angle was clamped to +/-pi
//            busy                 - operation in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
module cordic_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 11,   // must be 1..32
    parameter int N_ITER     = 16,   // 4..min(DATA_WIDTH,32)
    parameter int GUARD      = 2,
    parameter int GAIN_COMP  = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] z_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [DATA_WIDTH-1:0] z_out,
    output logic                  range_err,
    output logic                  busy
);

    localparam int c_xw = DATA_WIDTH + GUARD;
    localparam int c_zw = DATA_WIDTH + 1;
    localparam int c_pw = c_xw + c_zw;       // gain product / saturation width
    localparam int c_cw = $clog2(N_ITER);
    localparam int c_sh = 32 - FRAC_BITS;

    // round(atan(2^-i) * 2^32); beyond i=10 the value rounds to 2^(32-i)
    function automatic logic [63:0] atan_q32(input int i);
        case (i)
            0:       return 64'd3373259426;
            1:       return 64'd1991351318;
            2:       return 64'd1052175346;
            3:       return 64'd534100635;
            4:       return 64'd268086748;
            5:       return 64'd134174063;
            6:       return 64'd67103403;
            7:       return 64'd33553749;
            8:       return 64'd16777131;
            9:       return 64'd8388597;
            10:      return 64'd4194303;
            default: return 64'd1 << (32 - i);
        endcase
    endfunction

    // Q32 -> Q(FRAC_BITS) with round-half-up
    function automatic logic [63:0] q32(input logic [63:0] v);
        if (c_sh == 0) return v;
        return (v + (64'd1 << (c_sh - 1))) >> c_sh;
    endfunction

    localparam logic signed [c_zw-1:0] c_pi    = c_zw'(q32(64'd13493037705));
    localparam logic signed [c_zw-1:0] c_pi_2  = c_zw'(q32(64'd6746518852));
    localparam logic signed [c_pw-1:0] c_k     = c_pw'(q32(64'd2608131497));
    localparam logic signed [c_pw-1:0] c_half  = c_pw'(64'd1 << (FRAC_BITS - 1));
    localparam logic signed [c_pw-1:0] c_smax  = c_pw'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [c_pw-1:0] c_smin  = ~c_smax;
    localparam logic [c_cw-1:0]        c_last  = c_cw'(N_ITER - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [c_pw-1:0] v);
        if (v > c_smax) return c_smax[DATA_WIDTH-1:0];
        if (v < c_smin) return c_smin[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                r_state;
    logic [c_cw-1:0]           r_iter;
    logic signed [c_xw-1:0]    r_x, r_y;
    logic signed [c_zw-1:0]    r_z;
    logic [DATA_WIDTH-1:0]     r_x_out, r_y_out, r_z_out;
    logic                      r_err;

    logic                      w_accept;
    logic signed [c_xw-1:0]    w_xe, w_ye;
    logic signed [c_zw-1:0]    w_ze, w_zc;
    logic signed [c_xw-1:0]    w_ld_x, w_ld_y;
    logic signed [c_zw-1:0]    w_ld_z;
    logic                      w_ld_err;
    logic signed [c_zw-1:0]    w_atan_tab [N_ITER];
    logic signed [c_zw-1:0]    w_atan;
    logic                      w_d_pos;
    logic signed [c_xw-1:0]    w_xsh, w_ysh, w_x_n, w_y_n;
    logic signed [c_zw-1:0]    w_z_n;
    logic signed [c_pw-1:0]    w_gx, w_gy;

    assign in_ready  = (r_state == c_st_idle) | ((r_state == c_st_done) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign x_out     = r_x_out;
    assign y_out     = r_y_out;
    assign z_out     = r_z_out;
    assign range_err = r_err;

    for (genvar gi = 0; gi < N_ITER; gi++) begin : g_atan_tab
        assign w_atan_tab[gi] = c_zw'(q32(atan_q32(gi)));
    end

    // Quadrant pre-rotation so the micro-rotations only need to cover +/-pi/2
    assign w_xe = c_xw'($signed(x_in));
    assign w_ye = c_xw'($signed(y_in));
    assign w_ze = c_zw'($signed(z_in));

    always_comb begin
        w_ld_x   = w_xe;
        w_ld_y   = w_ye;
        w_ld_z   = '0;
        w_ld_err = 1'b0;
        w_zc     = w_ze;
        if (!mode) begin
            if (w_ze > c_pi) begin
                w_zc     = c_pi;
                w_ld_err = 1'b1;
            end else if (w_ze < -c_pi) begin
                w_zc     = -c_pi;
                w_ld_err = 1'b1;
            end
            w_ld_z = w_zc;
            if (w_zc > c_pi_2) begin
                w_ld_x = -w_ye;
                w_ld_y = w_xe;
                w_ld_z = w_zc - c_pi_2;
            end else if (w_zc < -c_pi_2) begin
                w_ld_x = w_ye;
                w_ld_y = -w_xe;
                w_ld_z = w_zc + c_pi_2;
            end
        end else if (w_xe[c_xw-1]) begin
            if (!w_ye[c_xw-1]) begin
                w_ld_x = w_ye;
                w_ld_y = -w_xe;
                w_ld_z = c_pi_2;
            end else begin
                w_ld_x = -w_ye;
                w_ld_y = w_xe;
                w_ld_z = -c_pi_2;
            end
        end
    end

    // One micro-rotation from the current register values
    assign w_atan  = w_atan_tab[r_iter];
    assign w_d_pos = mode ? r_y[c_xw-1] : ~r_z[c_zw-1];
    assign w_xsh   = r_x >>> r_iter;
    assign w_ysh   = r_y >>> r_iter;
    assign w_x_n   = w_d_pos ? (r_x - w_ysh)  : (r_x + w_ysh);
    assign w_y_n   = w_d_pos ? (r_y + w_xsh)  : (r_y - w_xsh);
    assign w_z_n   = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

    if (GAIN_COMP != 0) begin : g_gain
        assign w_gx = (c_pw'(w_x_n) * c_k + c_half) >>> FRAC_BITS;
        assign w_gy = (c_pw'(w_y_n) * c_k + c_half) >>> FRAC_BITS;
    end else begin : g_raw
        assign w_gx = c_pw'(w_x_n);
        assign w_gy = c_pw'(w_y_n);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= c_st_idle;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_state <= c_st_iter;
            r_iter  <= '0;
            r_x     <= w_ld_x;
            r_y     <= w_ld_y;
            r_z     <= w_ld_z;
            r_err   <= w_ld_err;
        end else begin
            case (r_state)
                c_st_iter: begin
                    r_x <= w_x_n;
                    r_y <= w_y_n;
                    r_z <= w_z_n;
                    if (r_iter == c_last) begin
                        r_state <= c_st_done;
                        r_iter  <= '0;
                        r_x_out <= sat(w_gx);
                        r_y_out <= sat(w_gy);
                        r_z_out <= sat(c_pw'(w_z_n));
                    end else begin
                        r_iter <= r_iter + c_cw'(1);
                    end
                end
                c_st_done: begin
                    if (out_ready) r_state <= c_st_idle;
                end
                c_st_idle: ;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_engine
// Purpose  : Self-checking bench for cordic_engine: table of directed
//            rotation/vectoring vectors with hand-computed results, plus
//            back-to-back, backpressure and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_engine;

    localparam int DW = 16;
    localparam int NI = 16;
    localparam int TOL_XY = 8;
    localparam int TOL_Z  = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          mode, in_valid, in_ready, out_valid, out_ready, range_err, busy;
    logic [DW-1:0] x_in, y_in, z_in, x_out, y_out, z_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_engine #(
        .DATA_WIDTH(DW), .FRAC_BITS(11), .N_ITER(NI), .GUARD(2), .GAIN_COMP(1)
    ) dut (
        .clk(clk), .arst(arst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .range_err(range_err), .busy(busy)
    );

    typedef struct {
        logic m;
        int   x, y, z;
        int   ex, ey, ez;
        logic eerr;
    } vec_t;

    vec_t vecs [15];

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input int got, input int exp, input int tol);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, got, exp, tol);
        end
    endtask

    task automatic present(input logic m, input int x, input int y, input int z);
        mode     = m;
        x_in     = DW'(x);
        y_in     = DW'(y);
        z_in     = DW'(z);
        in_valid = 1'b1;
    endtask

    // Edges until out_valid, bounded; a timeout shows up as a latency failure
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_result(input string tag, input int ex, input int ey,
                              input int ez, input logic eerr);
        chk({tag, "_x"},   sx(x_out), ex, TOL_XY);
        chk({tag, "_y"},   sx(y_out), ey, TOL_XY);
        chk({tag, "_z"},   sx(z_out), ez, TOL_Z);
        chk({tag, "_err"}, int'(range_err), int'(eerr), 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n;
        chk({tag, "_in_ready"}, int'(in_ready), 1, 0);
        present(v.m, v.x, v.y, v.z);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk({tag, "_latency"}, n, NI, 0);
        chk_result(tag, v.ex, v.ey, v.ez, v.eerr);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, int'(out_valid), 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad;
        logic [DW-1:0] hx, hy, hz;

        // rotation (x=2048 is 1.0): cos/sin of the angle, clamp cases, boundary at pi
        vecs[0]  = '{1'b0, 2048,     0,  1072,  1774,  1024,     0, 1'b0};
        vecs[1]  = '{1'b0, 2048,     0, -1072,  1774, -1024,     0, 1'b0};
        vecs[2]  = '{1'b0, 2048,     0,  3217,     0,  2048,     0, 1'b0};
        vecs[3]  = '{1'b0, 2048,     0, -4825, -1448, -1448,     0, 1'b0};
        vecs[4]  = '{1'b0, 2048,     0,  7000, -2048,     0,     0, 1'b1};
        vecs[5]  = '{1'b0, 2048,     0, -7000, -2048,     0,     0, 1'b1};
        vecs[6]  = '{1'b0, 2048,     0,  6434, -2048,     0,     0, 1'b0};
        vecs[7]  = '{1'b0, 2048,     0,  6435, -2048,     0,     0, 1'b1};
        vecs[8]  = '{1'b0, 1000,   500,     0,  1000,   500,     0, 1'b0};
        // vectoring: magnitude, ~0, atan2 over all quadrants; z_in ignored
        vecs[9]  = '{1'b1, -1024, 1024,     0,  1448,     0,  4825, 1'b0};
        vecs[10] = '{1'b1, -1024,-1024,     0,  1448,     0, -4825, 1'b0};
        vecs[11] = '{1'b1, 2048,     0,     0,  2048,     0,     0, 1'b0};
        vecs[12] = '{1'b1,    0, -2048,     0,  2048,     0, -3217, 1'b0};
        vecs[13] = '{1'b1, 1774,  1024,     0,  2048,     0,  1072, 1'b0};
        vecs[14] = '{1'b1, 2048,     0,  7000,  2048,     0,     0, 1'b0};

        arst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        #12;
        @(negedge clk); arst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  int'(in_ready),  1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_busy",      int'(busy),      0, 0);
        chk("rst_range_err", int'(range_err), 0, 0);
        chk("rst_x", sx(x_out), 0, 0);
        chk("rst_y", sx(y_out), 0, 0);
        chk("rst_z", sx(z_out), 0, 0);

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // back-to-back: second operation presented early, taken on the transfer edge
        out_ready = 1'b1;
        present(1'b0, 2048, 0, 3217);
        @(posedge clk); #1;
        present(1'b0, 2048, 0, -4825);
        chk("b2b_busy", int'(busy), 1, 0);
        wait_valid(n);
        chk("b2b_lat1", n, NI, 0);
        chk_result("b2b_1", 0, 2048, 0, 1'b0);
        chk("b2b_in_ready", int'(in_ready), 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid_drop", int'(out_valid), 0, 0);
        chk("b2b_busy2", int'(busy), 1, 0);
        wait_valid(n);
        chk("b2b_lat2", n, NI, 0);
        chk_result("b2b_2", -1448, -1448, 0, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // backpressure: result and flags hold, new operand refused for 10 cycles
        present(1'b0, 2048, 0, 1072);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp_lat1", n, NI, 0);
        chk_result("bp_1", 1774, 1024, 0, 1'b0);
        hx = x_out; hy = y_out; hz = z_out;
        present(1'b0, 2048, 0, -1072);
        chk("bp_in_ready", int'(in_ready), 0, 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || x_out !== hx || y_out !== hy || z_out !== hz)
                bad++;
        end
        chk("bp_hold_cycles_bad", bad, 0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_valid_drop", int'(out_valid), 0, 0);
        chk("bp_busy", int'(busy), 1, 0);
        wait_valid(n);
        chk("bp_lat2", n, NI, 0);
        chk_result("bp_2", 1774, -1024, 0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset at iteration 7 of an out-of-range op; outputs still hold prior result
        present(1'b0, 2048, 0, 7000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_err_before", int'(range_err), 1, 0);
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_before", int'(busy), 1, 0);
        arst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_busy",      int'(busy),      0, 0);
        chk("abort_range_err", int'(range_err), 0, 0);
        chk("abort_x", sx(x_out), 0, 0);
        chk("abort_y", sx(y_out), 0, 0);
        chk("abort_z", sx(z_out), 0, 0);
        @(negedge clk); arst = 1'b0;
        @(posedge clk); #1;
        run_vec("post_abort", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
